palindrome_gen: RTL and testbench

PALINDROME_GEN -- requirements
Module: palindrome_gen

---
 rtl/palindrome_gen_if.sv | 30 +++
 rtl/palindrome_gen.sv | 121 ++++++++++++
 tb/tb_palindrome_gen.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/palindrome_gen_if.sv
// -----------------------------------------------------------------------------
// palindrome_gen_if
//   Handshake bundle for palindrome_gen.
//   Word side  : in_valid, in_ready, in_data[N-1:0]
//   Serial side: out_bit, out_valid, out_ready, out_first, out_last
//   Modports   : slave  - the serializer (accepts words, emits bits)
//                master - the environment (supplies words, sinks bits)
// -----------------------------------------------------------------------------
interface palindrome_gen_if #(
  parameter int N = 4
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_bit;
  logic         out_valid;
  logic         out_ready;
  logic         out_first;
  logic         out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_bit, out_valid, out_first, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_bit, out_valid, out_first, out_last
  );
endinterface

// File: rtl/palindrome_gen.sv
// -----------------------------------------------------------------------------
// palindrome_gen
//   Accepts N-bit words and emits each one serially as a palindrome frame:
//   in_data[N-1] down to in_data[0], then back up to in_data[N-1].
//
//   Ports:
//     clk       - rising-edge clock
//     reset     - asynchronous, active-low reset
//     bus       - palindrome_gen_if.slave (word handshake + serial output)
//     frame_cnt - count of completed frames, wraps 255 -> 0
//
//   Configuration:
//     PALGEN_ODD_EN - when defined, the centre bit in_data[0] is sent once
//                     (2N-1 bit frames); otherwise it is repeated (2N bits).
//
//   in_ready is high while idle and during the consumed last beat of a frame,
//   so a waiting word starts on the very next cycle with no gap.
// -----------------------------------------------------------------------------
module palindrome_gen #(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                reset,
  palindrome_gen_if.slave     bus,
  output logic [7:0]          frame_cnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

`ifdef PALGEN_ODD_EN
  // Reverse phase skips index 0 so the centre bit appears only once.
  localparam logic [IW-1:0] REV_START = IW'(1);
`else
  localparam logic [IW-1:0] REV_START = IW'(0);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;     // bit position of the bit currently on out_bit
  logic [N-1:0]  data_q;
  logic          beat;
  logic          accept;

  assign beat          = bus.out_valid & bus.out_ready;
  assign bus.in_ready  = (state == IDLE) | (beat & bus.out_last);
  assign accept        = bus.in_valid & bus.in_ready;

  // NOTE: every register here, including the word register, is cleared by the
  // asynchronous reset; all state is assigned with <= so each edge sees only
  // the values from before that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      data_q        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_bit   <= 1'b0;
      frame_cnt     <= 8'd0;
    end else begin
      if (beat && bus.out_last) begin
        frame_cnt <= frame_cnt + 8'd1;
      end

      if (accept) begin
        // Fresh word: either from IDLE or chained onto the final beat of REV.
        state         <= FWD;
        data_q        <= bus.in_data;
        idx           <= LAST_IDX;
        bus.out_bit   <= bus.in_data[N-1];
        bus.out_valid <= 1'b1;
        bus.out_first <= 1'b1;
        bus.out_last  <= 1'b0;
      end else begin
        case (state)
          FWD: begin
            if (beat) begin
              bus.out_first <= 1'b0;
              if (idx == '0) begin
                state        <= REV;
                idx          <= REV_START;
                bus.out_bit  <= data_q[REV_START];
                bus.out_last <= (REV_START == LAST_IDX);
              end else begin
                idx         <= idx - IW'(1);
                bus.out_bit <= data_q[idx - IW'(1)];
              end
            end
          end

          REV: begin
            if (beat) begin
              if (bus.out_last) begin
                // Frame done and nothing waiting; out_bit keeps its value.
                state         <= IDLE;
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
              end else begin
                idx          <= idx + IW'(1);
                bus.out_bit  <= data_q[idx + IW'(1)];
                bus.out_last <= ((idx + IW'(1)) == LAST_IDX);
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_palindrome_gen.sv
// -----------------------------------------------------------------------------
// tb_palindrome_gen
//   Directed bench for palindrome_gen with N=4. Inputs change 1 time unit
//   after a rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_palindrome_gen;

  localparam int N = 4;
`ifdef PALGEN_ODD_EN
  localparam int FL = 7;
`else
  localparam int FL = 8;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] frame_cnt;
  int         checks;
  int         failures;

  palindrome_gen_if #(.N(N)) bus_if ();

  palindrome_gen #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offers a word and waits (bounded) until it is taken; returns at edge+1
  // of the accepting edge.
  task automatic accept_word(input logic [3:0] w, input string name);
    bit got;
    got = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = w;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus_if.in_ready === 1'b1) got = 1'b1;
      @(posedge clk);
      #1;
    end
    bus_if.in_valid = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_accept: in_ready never seen high, required 1", name);
    end
  endtask

  // Consumes one full frame with out_ready high, checking every beat.
  task automatic receive_frame(input logic [15:0] exp, input int len, input string name);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_bit !== exp[len-1-k] ||
          bus_if.out_first !== (k == 0) || bus_if.out_last !== (k == len-1)) begin
        failures++;
        $display("FAIL %s_beat%0d: valid=%b bit=%b first=%b last=%b, required valid=1 bit=%b first=%b last=%b",
                 name, k+1, bus_if.out_valid, bus_if.out_bit, bus_if.out_first, bus_if.out_last,
                 exp[len-1-k], (k == 0), (k == len-1));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.out_first !== 1'b0 || bus_if.out_last !== 1'b0 ||
        bus_if.out_bit !== 1'b0 || frame_cnt !== 8'd0 || bus_if.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: valid=%b first=%b last=%b bit=%b cnt=%0d rdy=%b, required 0 0 0 0 0 1",
               bus_if.out_valid, bus_if.out_first, bus_if.out_last, bus_if.out_bit, frame_cnt,
               bus_if.in_ready);
    end
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: valid=%b rdy=%b, required valid=0 rdy=1",
               bus_if.out_valid, bus_if.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [15:0] e;
`ifdef PALGEN_ODD_EN
    e = 16'b1011101;
`else
    e = 16'b10111101;
`endif
    accept_word(4'b1011, "basic");
    receive_frame(e, FL, "basic");
    @(negedge clk);
    checks++;
    if (bus_if.out_valid !== 1'b0 || frame_cnt !== 8'd1 || bus_if.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_end: valid=%b cnt=%0d rdy=%b, required valid=0 cnt=1 rdy=1",
               bus_if.out_valid, frame_cnt, bus_if.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] e1, e2;
    logic        eb, ef, el;
    int          j;
`ifdef PALGEN_ODD_EN
    e1 = 16'b1100011;
    e2 = 16'b0110110;
`else
    e1 = 16'b11000011;
    e2 = 16'b01100110;
`endif
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 4'b1100;
    @(posedge clk);
    #1;
    bus_if.in_data = 4'b0110;
    for (int k = 0; k < 2*FL; k++) begin
      j  = (k < FL) ? k : k - FL;
      eb = (k < FL) ? e1[FL-1-j] : e2[FL-1-j];
      ef = (j == 0);
      el = (j == FL-1);
      @(negedge clk);
      checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_bit !== eb ||
          bus_if.out_first !== ef || bus_if.out_last !== el) begin
        failures++;
        $display("FAIL b2b_beat%0d: valid=%b bit=%b first=%b last=%b, required valid=1 bit=%b first=%b last=%b",
                 k+1, bus_if.out_valid, bus_if.out_bit, bus_if.out_first, bus_if.out_last, eb, ef, el);
      end
      if (k == 0 || k == FL-1) begin
        checks++;
        if (bus_if.in_ready !== (k == FL-1)) begin
          failures++;
          $display("FAIL b2b_in_ready%0d: got %b, required %b", k+1, bus_if.in_ready, (k == FL-1));
        end
      end
      @(posedge clk);
      #1;
      if (k == FL-1) bus_if.in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (bus_if.out_valid !== 1'b0 || frame_cnt !== 8'd3) begin
      failures++;
      $display("FAIL b2b_end: valid=%b cnt=%0d, required valid=0 cnt=3", bus_if.out_valid, frame_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    logic [15:0] e;
`ifdef PALGEN_ODD_EN
    e = 16'b1001001;
`else
    e = 16'b10011001;
`endif
    accept_word(4'b1001, "stall");
    for (int k = 0; k < FL; k++) begin
      if (k == 2) begin
        bus_if.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          checks++;
          if (bus_if.out_valid !== 1'b1 || bus_if.out_bit !== 1'b0 || bus_if.out_first !== 1'b0 ||
              bus_if.out_last !== 1'b0 || bus_if.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold%0d: valid=%b bit=%b first=%b last=%b rdy=%b, required 1 0 0 0 0",
                     s, bus_if.out_valid, bus_if.out_bit, bus_if.out_first, bus_if.out_last,
                     bus_if.in_ready);
          end
          @(posedge clk);
          #1;
        end
        bus_if.out_ready = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_bit !== e[FL-1-k] ||
          bus_if.out_first !== (k == 0) || bus_if.out_last !== (k == FL-1)) begin
        failures++;
        $display("FAIL stall_beat%0d: valid=%b bit=%b first=%b last=%b, required valid=1 bit=%b first=%b last=%b",
                 k+1, bus_if.out_valid, bus_if.out_bit, bus_if.out_first, bus_if.out_last,
                 e[FL-1-k], (k == 0), (k == FL-1));
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if (bus_if.out_valid !== 1'b0 || frame_cnt !== 8'd4) begin
      failures++;
      $display("FAIL stall_end: valid=%b cnt=%0d, required valid=0 cnt=4", bus_if.out_valid, frame_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] e;
`ifdef PALGEN_ODD_EN
    e = 16'b1011101;
`else
    e = 16'b10111101;
`endif
    accept_word(4'b1011, "rstmid");
    repeat (4) begin
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1 || bus_if.out_first !== 1'b0 ||
        bus_if.out_last !== 1'b0 || frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rstmid_abort: valid=%b rdy=%b first=%b last=%b cnt=%0d, required 0 1 0 0 0",
               bus_if.out_valid, bus_if.in_ready, bus_if.out_first, bus_if.out_last, frame_cnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    accept_word(4'b1011, "rstmid_next");
    receive_frame(e, FL, "rstmid_next");
    @(negedge clk);
    checks++;
    if (frame_cnt !== 8'd1) begin
      failures++;
      $display("FAIL rstmid_cnt: got %0d, required 1", frame_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    int lasts;
    bit idle_seen;
    lasts = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 4'b1010;
    for (int c = 0; c < 3000 && lasts < 255; c++) begin
      @(negedge clk);
      if (bus_if.out_valid === 1'b1 && bus_if.out_last === 1'b1) begin
        lasts++;
        @(posedge clk);
        #1;
        if (lasts == 254) begin
          checks++;
          if (frame_cnt !== 8'd255) begin
            failures++;
            $display("FAIL wrap_255: got %0d, required 255", frame_cnt);
          end
        end
        if (lasts == 255) begin
          checks++;
          if (frame_cnt !== 8'd0) begin
            failures++;
            $display("FAIL wrap_0: got %0d, required 0", frame_cnt);
          end
          bus_if.in_valid = 1'b0;
        end
      end else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (lasts < 255) begin
      failures++;
      $display("FAIL wrap_timeout: saw %0d frame ends, required 255", lasts);
    end
    bus_if.in_valid = 1'b0;
    // One more frame was accepted alongside the wrap; let it drain.
    idle_seen = 1'b0;
    for (int c = 0; c < 40 && !idle_seen; c++) begin
      @(negedge clk);
      if (bus_if.out_valid === 1'b0) idle_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if (!idle_seen || frame_cnt !== 8'd1) begin
      failures++;
      $display("FAIL wrap_drain: idle=%b cnt=%0d, required idle=1 cnt=1", idle_seen, frame_cnt);
    end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    reset            = 1'b0;
    bus_if.in_valid  = 1'b1;   // offered during reset; must not be taken
    bus_if.in_data   = 4'hF;
    bus_if.out_ready = 1'b1;

    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid_frame();
    test_wrap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
